// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter and sequencer in front of the single-port
// data memory (one-cycle registered read, byte-masked write).
// M0 = CPU load/store unit, M1 = DMA/debug loader.
// Optional macro DMEM_ARB_RR_EN: round-robin arbitration in IDLE; when it is
// undefined, M0 always wins a contested IDLE cycle and no pointer exists.
//
// state | meaning
// ------+------------------------------------------
// IDLE  | either master may be granted
// OWN0  | M0 holds the lock, only M0 eligible
// OWN1  | M1 holds the lock, only M1 eligible
module dmem_arbiter #(
  parameter int SIZE     = 4096,
  parameter int LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_mask,
  input  logic        m0_lock,
  output logic        m0_gnt,
  output logic        m0_resp,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_mask,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic        m1_resp,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_sdata,
  output logic        mem_lenable,
  output logic [3:0]  mem_mask,
  input  logic [31:0] mem_ldata
);

  localparam int               CNT_W    = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  // Release fires in the cycle the counter would step to LOCK_MAX-1, so the
  // locked grant cycle plus the OWN cycles never exceed LOCK_MAX.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 2);
  localparam logic [31:0]      SIZE_W   = 32'(SIZE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resp0_q, resp0_d;
  logic             resp1_q, resp1_d;
  logic             err_q, err_d;
  logic             ld_q, ld_d;
`ifdef DMEM_ARB_RR_EN
  logic             ptr_q, ptr_d;
`endif

  logic        gnt0, gnt1;
  logic        g_any, g_we, g_oor;
  logic [31:0] g_addr, g_wdata;
  logic [3:0]  g_mask;
  logic        oor0, oor1;

  assign oor0 = {2'b00, m0_addr[31:2]} >= SIZE_W;
  assign oor1 = {2'b00, m1_addr[31:2]} >= SIZE_W;

  // State, lock counter, pointer and response pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      resp0_q <= 1'b0;
      resp1_q <= 1'b0;
      err_q   <= 1'b0;
      ld_q    <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp0_q <= resp0_d;
      resp1_q <= resp1_d;
      err_q   <= err_d;
      ld_q    <= ld_d;
`ifdef DMEM_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Next state and lock counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (gnt0 && m0_lock)      state_d = OWN0;
        else if (gnt1 && m1_lock) state_d = OWN1;
      end
      // The owner is always granted when it requests, so lock = 0 releases
      // both on a final transaction and when the owner has gone quiet.
      OWN0: begin
        if (!m0_lock || cnt_q == CNT_LAST) state_d = IDLE;
        else                               cnt_d   = cnt_q + CNT_W'(1);
      end
      OWN1: begin
        if (!m1_lock || cnt_q == CNT_LAST) state_d = IDLE;
        else                               cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant decode: owner only while locked, arbitration in IDLE, none in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state_q)
      OWN0: gnt0 = m0_req;
      OWN1: gnt1 = m1_req;
      default: begin
`ifdef DMEM_ARB_RR_EN
        if (m0_req && m1_req) begin
          gnt0 = !ptr_q;
          gnt1 = ptr_q;
        end else begin
          gnt0 = m0_req;
          gnt1 = m1_req;
        end
`else
        gnt0 = m0_req;
        gnt1 = m1_req && !m0_req;
`endif
      end
    endcase
    if (rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Any IDLE grant hands preference to the other master.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE) begin
      if (gnt0)      ptr_d = 1'b1;
      else if (gnt1) ptr_d = 1'b0;
    end
  end
`endif

  // Winner mux to the memory port and capture of the response attributes.
  always_comb begin
    g_any       = gnt0 | gnt1;
    g_we        = gnt1 ? m1_we    : m0_we;
    g_addr      = gnt1 ? m1_addr  : m0_addr;
    g_wdata     = gnt1 ? m1_wdata : m0_wdata;
    g_mask      = gnt1 ? m1_mask  : m0_mask;
    g_oor       = gnt1 ? oor1     : oor0;
    mem_addr    = g_any ? g_addr  : '0;
    mem_sdata   = g_any ? g_wdata : '0;
    mem_lenable = g_any && !g_we && !g_oor;
    mem_mask    = (g_any && g_we && !g_oor) ? g_mask : 4'h0;
    resp0_d     = gnt0;
    resp1_d     = gnt1;
    err_d       = g_any && g_oor;
    ld_d        = g_any && !g_we && !g_oor;
  end

  assign m0_gnt   = gnt0;
  assign m1_gnt   = gnt1;
  assign m0_resp  = resp0_q;
  assign m1_resp  = resp1_q;
  assign m0_err   = resp0_q & err_q;
  assign m1_err   = resp1_q & err_q;
  assign m0_rdata = (resp0_q && ld_q) ? mem_ldata : 32'h0;
  assign m1_rdata = (resp1_q && ld_q) ? mem_ldata : 32'h0;

endmodule
